write_back_stage: RTL and testbench

- Final (WB) stage of the 5-stage CPU pipeline.
- Selects the register-file write data from either the data-memory read value or the ALU result, under control of `ctr_mem_to_reg`.
- Registers the selected value, with enable-based stall support, before it drives the register-file write port.

---
 rtl/write_back_stage.sv | 61 ++++++
 tb/tb_write_back_stage.sv | 126 ++++++++++++
 2 files changed

// File: rtl/write_back_stage.sv
// write_back_stage: WB select mux feeding a stall-able write-data register (async active-low reset).
// Optional WB_LOAD_EXT_EN adds load alignment/extension on the datamem path; reset release is retimed by r_rel.
module write_back_stage #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
`ifdef WB_LOAD_EXT_EN
    input  logic [1:0]        ld_size,
    input  logic              ld_unsigned,
    input  logic [1:0]        ld_offset,
`endif
    input  logic [DATA_W-1:0] datamem,
    input  logic [DATA_W-1:0] alu,
    input  logic              ctr_mem_to_reg,
    input  logic              enable,
    output logic [DATA_W-1:0] writeback
);
    logic              r_rel;
    logic [DATA_W-1:0] r_writeback;
    logic [DATA_W-1:0] w_mem;
    logic [DATA_W-1:0] w_sel;

`ifdef WB_LOAD_EXT_EN
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    assign w_byte = datamem[{ld_offset, 3'b000} +: 8];
    assign w_half = datamem[{ld_offset[1], 4'b0000} +: 16];
    always_comb begin
        w_mem = datamem;
        if (ld_size == 2'b00)
            w_mem = {{(DATA_W-8){~ld_unsigned & w_byte[7]}}, w_byte};
        else if (ld_size == 2'b01)
            w_mem = {{(DATA_W-16){~ld_unsigned & w_half[15]}}, w_half};
    end
`else
    assign w_mem = datamem;
`endif

    assign w_sel     = ctr_mem_to_reg ? w_mem : alu;
    assign writeback = r_writeback;

    // r_rel and r_writeback form the 2-flop release chain: first capture is on the 2nd edge after release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rel       <= 1'b0;
            r_writeback <= RESET_VAL;
        end else begin
            r_rel <= 1'b1;
            if (r_rel && enable)
                r_writeback <= w_sel;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk)
        if (reset && r_rel && enable)
            assert (!$isunknown(ctr_mem_to_reg)) else $error("ctr_mem_to_reg unknown at enabled edge");
`endif
endmodule

// File: tb/tb_write_back_stage.sv
// tb_write_back_stage: randomized scoreboard bench; driver pushes model expectations, monitor pops after each edge.
module tb_write_back_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] datamem = '0;
    logic [31:0] alu = '0;
    logic        ctr_mem_to_reg = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] writeback;
    logic [1:0]  lsz = 2'b10;
    logic        lun = 1'b0;
    logic [1:0]  loff = 2'b00;

    int          checks = 0;
    int          errors = 0;
    int          since = 0;
    logic [31:0] exp_wb = '0;
    logic [31:0] q[$];

    write_back_stage dut (
        .clk            (clk),
        .reset          (reset),
`ifdef WB_LOAD_EXT_EN
        .ld_size        (lsz),
        .ld_unsigned    (lun),
        .ld_offset      (loff),
`endif
        .datamem        (datamem),
        .alu            (alu),
        .ctr_mem_to_reg (ctr_mem_to_reg),
        .enable         (enable),
        .writeback      (writeback)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, got, want, $time);
        end
    endtask

    // What the register file should see from memory for the current load controls
    function automatic logic [31:0] mem_val(input logic [31:0] m);
`ifdef WB_LOAD_EXT_EN
        int unsigned b;
        int unsigned h;
        b = (m >> (8 * loff)) & 32'hFF;
        h = (m >> (16 * loff[1])) & 32'hFFFF;
        if (lsz == 2'b00) return (!lun && b >= 128) ? b + 32'hFFFFFF00 : b;
        if (lsz == 2'b01) return (!lun && h >= 32768) ? h + 32'hFFFF0000 : h;
        return m;
`else
        return m;
`endif
    endfunction

    task automatic model_edge();
        if (!reset) begin
            exp_wb = '0;
            since  = 0;
        end else begin
            since++;
            if (since >= 2 && enable)
                exp_wb = ctr_mem_to_reg ? mem_val(datamem) : alu;
        end
        q.push_back(exp_wb);
    endtask

    task automatic step(input logic r, input logic [31:0] m, input logic [31:0] a, input logic s, input logic e);
        @(negedge clk);
        reset = r; datamem = m; alu = a; ctr_mem_to_reg = s; enable = e;
        #1 chk("hold_between_edges", writeback, exp_wb);
        model_edge();
    endtask

    task automatic async_reset();
        @(negedge clk);
        enable = 1'b1; ctr_mem_to_reg = 1'b0; alu = $urandom;
        #2 reset = 1'b0;
        #1 chk("async_reset", writeback, 32'h0);
        model_edge();
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) chk("wb_edge", writeback, q.pop_front());
    end

    initial begin
        #1 chk("pre_clk_reset", writeback, 32'h0);
        repeat (4) step(1'b0, $urandom, $urandom, 1'(($urandom)), 1'b0);
        step(1'b0, $urandom, $urandom, 1'b1, 1'b1);
        step(1'b1, 32'hFFFFFFFF, 32'h33333333, 1'b1, 1'b1);
        step(1'b1, 32'hFFFFFFFF, 32'h33333333, 1'b1, 1'b1);
        step(1'b1, 32'hFFFFFFFF, 32'h33333333, 1'b0, 1'b1);
        step(1'b1, 32'hFFFFFFFF, 32'h12345678, 1'b1, 1'b0);
        step(1'b1, 32'hFFFFFFFF, 32'h12345678, 1'b0, 1'b0);
        step(1'b1, 32'hFFFFFFFF, 32'h12345678, 1'b0, 1'b1);
        async_reset();
        step(1'b0, $urandom, $urandom, 1'b0, 1'b1);
        step(1'b1, $urandom, $urandom, 1'b0, 1'b1);
        step(1'b1, 32'hCAFEF00D, 32'h0, 1'b1, 1'b1);
`ifdef WB_LOAD_EXT_EN
        lsz = 2'b00; loff = 2'b00; lun = 1'b0;
        step(1'b1, 32'h000080FF, 32'h0, 1'b1, 1'b1);
        lsz = 2'b01; lun = 1'b1;
        step(1'b1, 32'h000080FF, 32'h0, 1'b1, 1'b1);
        lun = 1'b0;
        step(1'b1, 32'h000080FF, 32'h0, 1'b1, 1'b1);
`endif
        for (int i = 0; i < 300; i++) begin
            lsz = 2'($urandom); lun = 1'($urandom); loff = 2'($urandom);
            step(1'b1, $urandom, $urandom, 1'($urandom), ($urandom % 4) != 0);
        end
        async_reset();
        for (int i = 0; i < 6; i++)
            step(i > 0, $urandom, $urandom, 1'($urandom), 1'b1);
        @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
